axi_wr_rsp_arb: RTL and testbench

Parametrised AXI write-response (B channel) slave-side generator. Merges write-completion events from NUM_SRC independent backend sources through a round-robin arbiter into a DEPTH-entry response FIFO, and drives a single AXI B channel with a compliant valid/ready handshake. It generalises the fixed 4-bit-ID, 1-bit-user B channel to configurable ID/user widths and adds buffering, multi-source arbitration and error statistics. It sits between the write-datapath completion logic and the AXI slave port.

---
 rtl/axi_rsp_pkg.sv | 18 +
 rtl/rsp_fifo.sv | 52 +++++
 rtl/axi_wr_rsp_arb.sv | 104 ++++++++++
 tb/tb_axi_wr_rsp_arb.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rsp_pkg.sv
// Shared types and constants for the AXI write-response generator.
// Response entries are packed as {id, resp, user}.
package axi_rsp_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    localparam int ERR_CNT_W = 16;

    function automatic int entry_w(input int id_w, input int user_w);
        return id_w + 2 + user_w;
    endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Generic synchronous FIFO with registered storage and no write-to-read bypass.
// The head output reads as zero while the FIFO is empty.
module rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_i) wr_d = wr_q + AW'(1);
        if (pop_i)  rd_d = rd_q + AW'(1);
        if (push_i && !pop_i)      cnt_d = cnt_q + (AW + 1)'(1);
        else if (!push_i && pop_i) cnt_d = cnt_q - (AW + 1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= wdata_i;
    end

    assign head_o  = (cnt_q != '0) ? mem_q[rd_q] : '0;
    assign count_o = cnt_q;

endmodule

// File: rtl/axi_wr_rsp_arb.sv
// AXI B-channel generator: round-robin merge of completion sources into a
// response FIFO, with a saturating count of SLVERR/DECERR responses issued.
module axi_wr_rsp_arb
    import axi_rsp_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 1,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC*ID_WIDTH-1:0]   src_id,
    input  logic [NUM_SRC*2-1:0]          src_resp,
    input  logic [NUM_SRC*USER_WIDTH-1:0] src_user,
    output logic                          bvalid,
    input  logic                          bready,
    output logic [ID_WIDTH-1:0]           bid,
    output logic [1:0]                    bresp,
    output logic [USER_WIDTH-1:0]         buser,
    output logic [$clog2(DEPTH):0]        occupancy,
    output logic [ERR_CNT_W-1:0]          err_cnt
);

    localparam int ENTRY_W = entry_w(ID_WIDTH, USER_WIDTH);
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int RR_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [RR_W-1:0]      rr_q, rr_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0]     count;
    logic [ENTRY_W-1:0]   push_entry, head;
    logic                 can_push, push, pop, gnt_vld;
    int                   gnt, idx;

    assign pop      = bvalid & bready;
    assign can_push = (count != FULL_CNT) | pop;

    // Search starts at rr_q and wraps, so the last-served source goes to the back.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = 0;
        idx     = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (int'(rr_q) + k) % NUM_SRC;
            if (!gnt_vld && src_valid[idx]) begin
                gnt_vld = 1'b1;
                gnt     = idx;
            end
        end
    end

    always_comb begin
        src_ready = '0;
        if (!rst) begin
            if (NUM_SRC == 1)  src_ready[0]   = can_push;
            else if (gnt_vld)  src_ready[gnt] = can_push;
        end
    end

    assign push       = |(src_ready & src_valid);
    assign push_entry = {src_id[gnt*ID_WIDTH +: ID_WIDTH],
                         src_resp[gnt*2 +: 2],
                         src_user[gnt*USER_WIDTH +: USER_WIDTH]};

    rsp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_entry),
        .head_o  (head),
        .count_o (count)
    );

    assign bvalid              = (count != '0);
    assign {bid, bresp, buser} = head;
    assign occupancy           = count;
    assign err_cnt             = err_q;

    always_comb begin
        rr_d  = rr_q;
        err_d = err_q;
        if (push) rr_d = RR_W'((gnt + 1) % NUM_SRC);
        if (pop && bresp[1] && (err_q != '1)) err_d = err_q + ERR_CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q  <= '0;
            err_q <= '0;
        end else begin
            rr_q  <= rr_d;
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_axi_wr_rsp_arb.sv
// Scoreboard bench for axi_wr_rsp_arb: a queue-based reference model predicts
// grants, occupancy and error count; a monitor checks every presented B response.
module tb_axi_wr_rsp_arb;
    import axi_rsp_pkg::*;

    localparam int NUM_SRC = 2;
    localparam int ID_W    = 4;
    localparam int USER_W  = 1;
    localparam int DEPTH   = 4;

    typedef struct {
        int id;
        int resp;
        int user;
    } rsp_t;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [NUM_SRC-1:0]          src_valid = '0;
    logic [NUM_SRC-1:0]          src_ready;
    logic [NUM_SRC*ID_W-1:0]     src_id = '0;
    logic [NUM_SRC*2-1:0]        src_resp = '0;
    logic [NUM_SRC*USER_W-1:0]   src_user = '0;
    logic                        bvalid;
    logic                        bready = 1'b0;
    logic [ID_W-1:0]             bid;
    logic [1:0]                  bresp;
    logic [USER_W-1:0]           buser;
    logic [$clog2(DEPTH):0]      occupancy;
    logic [15:0]                 err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    rsp_t mq[$];
    rsp_t sb[$];
    int   m_occ = 0;
    int   m_rr  = 0;
    int   m_err = 0;
    bit   in_rst = 1'b1;
    logic [NUM_SRC-1:0] acc_mask = '0;

    axi_wr_rsp_arb #(
        .NUM_SRC    (NUM_SRC),
        .ID_WIDTH   (ID_W),
        .USER_WIDTH (USER_W),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_id    (src_id),
        .src_resp  (src_resp),
        .src_user  (src_user),
        .bvalid    (bvalid),
        .bready    (bready),
        .bid       (bid),
        .bresp     (bresp),
        .buser     (buser),
        .occupancy (occupancy),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: evaluates the cycle's transfer rules on the negedge
    // and applies their effect as of the coming posedge.
    always @(negedge clk) begin
        int g;
        bit found;
        bit can;
        bit do_pop;
        logic [NUM_SRC-1:0] er;
        rsp_t e;
        if (rst) begin
            chk("rst_src_ready", 32'(src_ready), 32'h0);
            if (in_rst) begin
                chk("rst_bvalid", 32'(bvalid), 32'h0);
                chk("rst_occupancy", 32'(occupancy), 32'h0);
                chk("rst_err_cnt", 32'(err_cnt), 32'h0);
                chk("rst_bid", 32'({bid, bresp, buser}), 32'h0);
            end
            in_rst = 1'b1;
            m_occ = 0;
            m_rr = 0;
            m_err = 0;
            mq.delete();
            sb.delete();
            acc_mask = '0;
        end else begin
            in_rst = 1'b0;
            chk("occupancy", 32'(occupancy), 32'(m_occ));
            chk("bvalid", 32'(bvalid), 32'(m_occ != 0));
            chk("err_cnt", 32'(err_cnt), 32'(m_err));
            do_pop = (m_occ != 0) && bready;
            can = (m_occ < DEPTH) || do_pop;
            found = 1'b0;
            g = 0;
            for (int k = 0; k < NUM_SRC; k++) begin
                if (!found && src_valid[(m_rr + k) % NUM_SRC]) begin
                    found = 1'b1;
                    g = (m_rr + k) % NUM_SRC;
                end
            end
            er = '0;
            if (found && can) er[g] = 1'b1;
            chk("src_ready", 32'(src_ready), 32'(er));
            acc_mask = er;
            if (do_pop) begin
                e = mq.pop_front();
                if (e.resp >= 2 && m_err < 65535) m_err++;
                m_occ--;
            end
            if (found && can) begin
                e.id   = int'(src_id[g*ID_W +: ID_W]);
                e.resp = int'(src_resp[g*2 +: 2]);
                e.user = int'(src_user[g*USER_W +: USER_W]);
                mq.push_back(e);
                sb.push_back(e);
                m_occ++;
                m_rr = (g + 1) % NUM_SRC;
            end
        end
    end

    // Monitor: every presented response must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && bvalid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL b_unexpected: got bid %0h with no response expected", bid);
            end else begin
                chk("b_id", 32'(bid), 32'(sb[0].id));
                chk("b_resp", 32'(bresp), 32'(sb[0].resp));
                chk("b_user", 32'(buser), 32'(sb[0].user));
                if (bready) void'(sb.pop_front());
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic v, input logic [ID_W-1:0] id,
                           input logic [1:0] r, input logic [USER_W-1:0] u);
        src_valid[i]              = v;
        src_id[i*ID_W +: ID_W]    = id;
        src_resp[i*2 +: 2]        = r;
        src_user[i*USER_W +: USER_W] = u;
    endtask

    task automatic refill_ok();
        for (int i = 0; i < NUM_SRC; i++)
            if (acc_mask[i])
                set_src(i, 1'b1, ID_W'($urandom), {1'b0, 1'($urandom)}, USER_W'($urandom));
    endtask

    task automatic drop_accepted();
        for (int i = 0; i < NUM_SRC; i++)
            if (acc_mask[i]) src_valid[i] = 1'b0;
    endtask

    initial begin
        // Reset held three cycles, then idle.
        repeat (3) cycle();
        rst = 1'b0;
        repeat (3) cycle();

        // Single push from source 0.
        bready = 1'b1;
        set_src(0, 1'b1, 4'h3, OKAY, 1'b1);
        #1;
        chk("single_ready", 32'(src_ready), 32'h1);
        cycle();
        src_valid = '0;
        chk("single_bvalid", 32'(bvalid), 32'h1);
        chk("single_bid", 32'(bid), 32'h3);
        cycle();
        chk("single_drain", 32'(bvalid), 32'h0);
        repeat (2) cycle();

        // Both sources continuously valid: grants alternate.
        set_src(0, 1'b1, 4'h1, OKAY, 1'b0);
        set_src(1, 1'b1, 4'h2, EXOKAY, 1'b1);
        repeat (6) begin
            cycle();
            refill_ok();
        end
        src_valid = '0;
        repeat (3) cycle();

        // Fill under backpressure, then push and pop together at full.
        bready = 1'b0;
        set_src(0, 1'b1, 4'h5, OKAY, 1'b0);
        repeat (5) begin
            cycle();
            refill_ok();
        end
        chk("full_occupancy", 32'(occupancy), 32'd4);
        chk("full_ready", 32'(src_ready), 32'h0);
        bready = 1'b1;
        #1;
        chk("full_pushpop_ready", 32'(src_ready), 32'h1);
        cycle();
        bready = 1'b0;
        src_valid = '0;
        chk("full_occ_kept", 32'(occupancy), 32'd4);

        // Long stall with sources pending, then release.
        set_src(0, 1'b1, 4'hA, OKAY, 1'b1);
        set_src(1, 1'b1, 4'hB, EXOKAY, 1'b0);
        repeat (10) cycle();
        bready = 1'b1;
        repeat (10) begin
            cycle();
            drop_accepted();
        end
        src_valid = '0;
        repeat (3) cycle();

        // Error counting over SLVERR, DECERR, EXOKAY.
        set_src(0, 1'b1, 4'h7, SLVERR, 1'b0);
        cycle();
        set_src(0, 1'b1, 4'h8, DECERR, 1'b1);
        cycle();
        set_src(0, 1'b1, 4'h9, EXOKAY, 1'b0);
        cycle();
        src_valid = '0;
        repeat (3) cycle();
        chk("err_three", 32'(err_cnt), 32'd2);

        // Randomised traffic with a reset in the middle.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_SRC; i++)
                if (!src_valid[i] || acc_mask[i])
                    set_src(i, 1'($urandom_range(0, 1)), ID_W'($urandom),
                            2'($urandom), USER_W'($urandom));
            bready = ($urandom_range(0, 3) != 0);
            rst = (n == 200);
            cycle();
        end
        rst = 1'b0;
        src_valid = '0;
        bready = 1'b1;
        repeat (6) cycle();

        // Saturation: reset, then stream SLVERR until the counter tops out.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        set_src(0, 1'b1, 4'hE, SLVERR, 1'b1);
        for (int n = 0; n < 70000 && m_err < 65535; n++) cycle();
        if (m_err < 65535) begin
            n_tests++;
            n_fail++;
            $display("FAIL sat_budget: got %0d handshakes, want 65535", m_err);
        end
        chk("err_at_max", 32'(err_cnt), 32'hFFFF);
        repeat (4) cycle();
        src_valid = '0;
        repeat (3) cycle();
        chk("err_saturated", 32'(err_cnt), 32'hFFFF);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
